// File: rtl/hsv_threshold_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hsv_threshold_pipe
// Description : Two-stage pipelined HSV band / binary thresholder with
//               frame-synchronous programmable limits and per-frame
//               foreground pixel statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_threshold_pipe #(
    parameter int DATA_W    = 8,
    parameter int CH        = 3,
    parameter int CNT_W     = 22,
    parameter int DEF_LOWER = 0,
    parameter int DEF_UPPER = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [DATA_W+CH-1:0] cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_sof,
    input  logic                 in_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [CNT_W-1:0]     stat_count,
    output logic                 stat_valid
);

    localparam logic [DATA_W-1:0] c_def_lower = DATA_W'(DEF_LOWER);
    localparam logic [DATA_W-1:0] c_def_upper = DATA_W'(DEF_UPPER);
    localparam logic [3:0]        c_ctrl_addr = 4'(2 * CH);

    logic [DATA_W-1:0] r_sh_lower  [CH];
    logic [DATA_W-1:0] r_sh_upper  [CH];
    logic [DATA_W-1:0] r_act_lower [CH];
    logic [DATA_W-1:0] r_act_upper [CH];
    logic              r_sh_mode, r_sh_inv, r_act_mode, r_act_inv;
    logic [CH-1:0]     r_sh_en, r_act_en;

    logic              w_adv, w_accept, w_load;
    logic              w_mode, w_inv;
    logic [CH-1:0]     w_en;
    logic [CH-1:0]     w_res;

    logic              r_s1_valid, r_s1_mode, r_s1_inv, r_s1_sof, r_s1_eof;
    logic [CH-1:0]     r_s1_res;
    logic              w_hit, w_fg;

    logic              w_fire, w_out_fg;
    logic [CNT_W-1:0]  r_cnt, w_cnt_base, w_cnt_next;

    logic              w_unused_cfg;
    assign w_unused_cfg = ^cfg_data;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;
    assign w_load   = w_accept && in_sof;

    // The accepted sof pixel sees the shadow values it is about to commit.
    assign w_mode = w_load ? r_sh_mode : r_act_mode;
    assign w_inv  = w_load ? r_sh_inv  : r_act_inv;
    assign w_en   = w_load ? r_sh_en   : r_act_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                r_sh_lower[c] <= c_def_lower;
                r_sh_upper[c] <= c_def_upper;
            end
            r_sh_mode <= 1'b0;
            r_sh_inv  <= 1'b0;
            r_sh_en   <= '1;
        end else if (cfg_we) begin
            for (int c = 0; c < CH; c++) begin
                if (cfg_addr == 4'(2 * c))
                    r_sh_lower[c] <= cfg_data[DATA_W-1:0];
                if (cfg_addr == 4'(2 * c + 1))
                    r_sh_upper[c] <= cfg_data[DATA_W-1:0];
            end
            if (cfg_addr == c_ctrl_addr) begin
                r_sh_mode <= cfg_data[0];
                r_sh_inv  <= cfg_data[1];
                r_sh_en   <= cfg_data[CH+1:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                r_act_lower[c] <= c_def_lower;
                r_act_upper[c] <= c_def_upper;
            end
            r_act_mode <= 1'b0;
            r_act_inv  <= 1'b0;
            r_act_en   <= '1;
        end else if (w_load) begin
            r_act_lower <= r_sh_lower;
            r_act_upper <= r_sh_upper;
            r_act_mode  <= r_sh_mode;
            r_act_inv   <= r_sh_inv;
            r_act_en    <= r_sh_en;
        end
    end

    genvar c;
    for (c = 0; c < CH; c++) begin : g_ch
        logic [DATA_W-1:0] w_x, w_lo, w_up;
        logic              w_band;
        assign w_x  = in_data[c*DATA_W +: DATA_W];
        assign w_lo = w_load ? r_sh_lower[c] : r_act_lower[c];
        assign w_up = w_load ? r_sh_upper[c] : r_act_upper[c];
        // lower > upper describes a band that wraps through zero (hue).
        assign w_band = (w_lo <= w_up) ? ((w_x > w_lo) && (w_x <= w_up))
                                       : ((w_x > w_lo) || (w_x <= w_up));
        if (c == 0) begin : g_ch0
            assign w_res[c] = w_mode ? (!w_en[c] || w_band) : (w_x >= w_lo);
        end else begin : g_chn
            assign w_res[c] = !w_en[c] || w_band;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_res   <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_res  <= w_res;
                r_s1_mode <= w_mode;
                r_s1_inv  <= w_inv;
                r_s1_sof  <= in_sof;
                r_s1_eof  <= in_eof;
            end
        end
    end

    assign w_hit = r_s1_mode ? (&r_s1_res) : r_s1_res[0];
    assign w_fg  = w_hit ^ r_s1_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= {DATA_W{w_fg}};
                out_sof  <= r_s1_sof;
                out_eof  <= r_s1_eof;
            end
        end
    end

    assign w_fire     = out_valid && out_ready;
    assign w_out_fg   = out_data[0];
    assign w_cnt_base = out_sof ? '0 : r_cnt;
    assign w_cnt_next = (w_out_fg && (w_cnt_base != '1)) ? (w_cnt_base + CNT_W'(1))
                                                          : w_cnt_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            stat_count <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (w_fire) begin
                if (out_eof) begin
                    stat_count <= w_cnt_next;
                    stat_valid <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsv_threshold_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsv_threshold_pipe
// Description : Scoreboard bench for hsv_threshold_pipe (CNT_W 22 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsv_threshold_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [10:0] cfg_data = '0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_sof, out_eof, stat_valid;
    logic [7:0]  out_data;
    logic [21:0] stat_count;
    logic        in_ready4, out_valid4, out_sof4, out_eof4, stat_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  stat_count4;

    always #5 clk = ~clk;

    hsv_threshold_pipe #(.DATA_W(8), .CH(3), .CNT_W(22)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
        .out_eof(out_eof), .stat_count(stat_count), .stat_valid(stat_valid)
    );

    hsv_threshold_pipe #(.DATA_W(8), .CH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_sof(out_sof4),
        .out_eof(out_eof4), .stat_count(stat_count4), .stat_valid(stat_valid4)
    );

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t q[$];
    int   sq22[$];
    int   sq4[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [7:0] m_sh_lo[3], m_sh_up[3], m_act_lo[3], m_act_up[3];
    bit         m_sh_mode, m_sh_inv, m_act_mode, m_act_inv;
    bit [2:0]   m_sh_en, m_act_en;
    int         m_cnt22, m_cnt4;

    bit bp = 0;
    int bp_i = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bp) begin
            out_ready = pat[bp_i % 4];
            bp_i++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_sh_lo[c] = 8'd0;  m_sh_up[c] = 8'd255;
            m_act_lo[c] = 8'd0; m_act_up[c] = 8'd255;
        end
        m_sh_mode = 0; m_sh_inv = 0; m_sh_en = 3'b111;
        m_act_mode = 0; m_act_inv = 0; m_act_en = 3'b111;
        m_cnt22 = 0; m_cnt4 = 0;
        q.delete(); sq22.delete(); sq4.delete();
    endtask

    function automatic bit model_fg(input logic [23:0] px);
        bit hit;
        logic [7:0] x, lo, up;
        if (!m_act_mode) begin
            hit = (px[7:0] >= m_act_lo[0]);
        end else begin
            hit = 1;
            for (int c = 0; c < 3; c++) begin
                x = px[c*8 +: 8]; lo = m_act_lo[c]; up = m_act_up[c];
                if (m_act_en[c]) begin
                    if (lo <= up) hit = hit & ((x > lo) && (x <= up));
                    else          hit = hit & ((x > lo) || (x <= up));
                end
            end
        end
        return hit ^ m_act_inv;
    endfunction

    task automatic cfg_wr(input logic [3:0] addr, input logic [10:0] data);
        cfg_we = 1; cfg_addr = addr; cfg_data = data;
        if (addr < 6) begin
            if (addr[0]) m_sh_up[addr/2] = data[7:0];
            else         m_sh_lo[addr/2] = data[7:0];
        end else if (addr == 6) begin
            m_sh_mode = data[0]; m_sh_inv = data[1]; m_sh_en = data[4:2];
        end
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic send(input logic [23:0] px, input bit sof, input bit eof, input bit lat = 0);
        bit acc = 0;
        bit fg;
        exp_t e;
        int n = 0;
        in_valid = 1; in_data = px; in_sof = sof; in_eof = eof;
        while (!acc && n < 100) begin
            #1;
            acc = in_ready;
            if (acc) begin
                if (sof) begin
                    m_act_lo = m_sh_lo; m_act_up = m_sh_up;
                    m_act_mode = m_sh_mode; m_act_inv = m_sh_inv; m_act_en = m_sh_en;
                    m_cnt22 = 0; m_cnt4 = 0;
                end
                fg = model_fg(px);
                e.data = fg ? 8'hFF : 8'h00; e.sof = sof; e.eof = eof;
                e.acc_cyc = cyc; e.chk_lat = lat;
                q.push_back(e);
                if (fg) begin
                    if (m_cnt22 < (1 << 22) - 1) m_cnt22++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
                if (eof) begin
                    sq22.push_back(m_cnt22); sq4.push_back(m_cnt4);
                    m_cnt22 = 0; m_cnt4 = 0;
                end
            end
            @(negedge clk);
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 0; in_sof = 0; in_eof = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || sq22.size() != 0 || sq4.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size() + sq22.size() + sq4.size(), 0);
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst_n) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sof", out_sof, e.sof);
                    check("out_eof", out_eof, e.eof);
                    if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
                end
            end
            if (stat_valid) begin
                if (sq22.size() == 0) check("unexpected_stat", 1, 0);
                else check("stat_count", stat_count, sq22.pop_front());
            end
            if (stat_valid4) begin
                if (sq4.size() == 0) check("unexpected_stat4", 1, 0);
                else check("stat_count4", stat_count4, sq4.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stat_count", stat_count, 0);
        check("rst_stat_valid", stat_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1;
        @(negedge clk);

        // Binary mode with defaults, then a shadow write that waits for sof
        send(24'd0, 1, 0, 1); send(24'd1, 0, 0, 1); send(24'd255, 0, 1, 1);
        cfg_wr(4'd0, 11'd10);
        send(24'd9, 0, 0);
        send(24'd9, 1, 0); send(24'd10, 0, 1);
        drain();

        // Band mode on all channels
        cfg_wr(4'd6, 11'd29);
        cfg_wr(4'd0, 11'd20); cfg_wr(4'd1, 11'd40);
        cfg_wr(4'd2, 11'd0);  cfg_wr(4'd3, 11'd255);
        cfg_wr(4'd4, 11'd0);  cfg_wr(4'd5, 11'd255);
        send({8'd100, 8'd100, 8'd20}, 1, 0);
        send({8'd100, 8'd100, 8'd21}, 0, 0);
        send({8'd100, 8'd100, 8'd40}, 0, 0);
        send({8'd100, 8'd100, 8'd41}, 0, 0);
        send({8'd100, 8'd0,   8'd30}, 0, 0);
        send({8'd0,   8'd100, 8'd30}, 0, 1);
        drain();

        // Wrapping hue band, then inverted, then all channels disabled
        cfg_wr(4'd0, 11'd200); cfg_wr(4'd1, 11'd10); cfg_wr(4'd6, 11'd5);
        send(24'd250, 1, 0); send(24'd5, 0, 0); send(24'd100, 0, 1);
        cfg_wr(4'd6, 11'd7);
        send(24'd250, 1, 0); send(24'd5, 0, 0); send(24'd100, 0, 1);
        cfg_wr(4'd6, 11'd1);
        send(24'd100, 1, 1);
        cfg_wr(4'd6, 11'd3);
        send(24'd100, 1, 1);
        drain();

        // Backpressure with a continuous input stream
        cfg_wr(4'd6, 11'd5);
        bp = 1;
        for (int i = 0; i < 8; i++) send(24'((i * 37) % 256), i == 0, i == 7);
        drain();
        bp = 0; out_ready = 1;
        @(negedge clk);

        // Frame statistics incl. one-pixel frame and 4-bit saturation
        cfg_wr(4'd6, 11'd0); cfg_wr(4'd0, 11'd10);
        send(24'd50, 1, 0); send(24'd5, 0, 0); send(24'd60, 0, 0);
        send(24'd3, 0, 0);  send(24'd70, 0, 1);
        send(24'd200, 1, 1);
        for (int i = 0; i < 20; i++) send(24'd100, i == 0, i == 19);
        drain();

        // Reset with beats in flight
        out_ready = 0;
        send(24'd5, 1, 0); send(24'd50, 0, 0);
        #2;
        rst_n = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_stat_valid", stat_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        @(negedge clk);
        send(24'd0, 0, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hsv_threshold_pipe.md
Name: hsv_threshold_pipe

Overview:
- Parametrised, pipelined successor to the combinational HSV/binary thresholders in the pixel pre-processing chain ahead of the CNN feature extractor.
- Accepts CH-channel pixels on a valid/ready stream and emits one DATA_W-bit mask pixel per input pixel.
- Thresholds are runtime-programmable and frame-synchronous, and band limits may wrap around (for hue).
- Counts foreground pixels per frame for downstream statistics.

Parameters:
DATA_W, 8, bits per channel and per output pixel
CH, 3, channels per pixel (H,S,V order: ch0 in LSBs)
CNT_W, 22, width of per-frame foreground counter (saturating)
DEF_LOWER, 0, reset value of every lower threshold
DEF_UPPER, 255, reset value of every upper threshold

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  4  config register address
cfg_data  in  DATA_W+CH  config write data (LSBs used for thresholds)
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_data  in  CH*DATA_W  pixel channels
in_sof  in  1  first pixel of frame (qualified by in_valid&in_ready)
in_eof  in  1  last pixel of frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  all-ones (foreground) or 0
out_sof  out  1  sof delayed with data
out_eof  out  1  eof delayed with data
stat_count  out  CNT_W  foreground count of last completed frame
stat_valid  out  1  one-cycle pulse when stat_count updates

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sof=0, out_eof=0, stat_count=0, stat_valid=0, pipeline valids cleared, running counter 0. Shadow and active regs: lower=DEF_LOWER, upper=DEF_UPPER, mode=0, invert=0, enable mask all ones. Mid-frame reset discards in-flight beats; no partial stat is reported.
- Config map (shadow regs): addr 2c = lower[c], 2c+1 = upper[c] (c<CH), data[DATA_W-1:0]. Addr 2*CH = control: bit0 mode (0 binary, 1 band), bit1 invert, bits[CH+1:2] channel enable. Other addresses ignored. Writes apply to shadow only.
- Shadow→active copy occurs on the cycle an in_sof beat is accepted; that sof pixel uses the new values. A cfg_we in the same cycle writes shadow after the copy, so that write takes effect next frame.
- Pipeline: 2 stages, both advance when adv = !out_valid | out_ready. in_ready = adv (combinational). Latency 2 cycles from acceptance to out_valid under continuous out_ready; full throughput, 1 pixel/cycle. Stalls hold all stage contents; no beat is lost or duplicated.
- Stage 1 registers the per-channel comparison results:
  - Band, lower<=upper: lower < x <= upper.
  - Band wrap, lower>upper: x > lower OR x <= upper.
  - Disabled channel: result forced true.
  - Binary mode: ch0 only, x >= lower[0].
- Stage 2:
  - band hit = AND of channel results; binary hit = ch0 result.
  - fg = hit XOR invert.
  - out_data = fg ? all-ones : 0.
- Statistics, evaluated on output handshake (out_valid & out_ready):
  - fg increments the running counter, saturating at 2^CNT_W-1.
  - out_sof restarts the count at fg.
  - out_eof latches the final value (including that beat) into stat_count, pulses stat_valid, and clears the counter.
  - A beat with both sof and eof is a one-pixel frame.
- All-disabled channels in band mode: every pixel is foreground (background if invert=1).
- sof/eof are not checked for pairing; a missing eof leaves the count running, and the next sof restarts it.

Test Plan:
- Reset defaults, binary mode, ch0 values 0,1,255 with out_ready=1 -> out_data 255,255,255 two cycles after each accept. After writing addr0=10, pixel 9 -> 0 and pixel 10 -> 255, taking effect only after the next sof.
- Band mode, enable all, ch0 lower 20 upper 40, others 0/255. H=20 -> 0, H=21 -> 255, H=40 -> 255, H=41 -> 0. Any S/V channel equal to 0 -> 0 (0 is not > 0).
- Wrap band, ch0 lower=200 upper=10, enable ch0 only. H=250 -> 255, H=5 -> 255, H=100 -> 0. With invert=1 the results are inverted.
- Backpressure: 8-pixel frame, out_ready toggling 1,0,0,1 pattern with in_valid constant. Output order and count match input exactly, and in_ready=0 exactly while out_valid=1 and out_ready=0.
- Stats: frame of 5 pixels with 3 foreground, then a 1-pixel sof+eof foreground frame. stat_valid pulses twice, with stat_count=3 then 1. At CNT_W=4, a 20-foreground frame reports 15.
- Reset asserted mid-frame with beats in flight -> out_valid drops immediately, no stat_valid, and active thresholds return to defaults.
